// File: rtl/pipe_skid_register_if.sv
// -----------------------------------------------------------------------------
// pipe_skid_register_if
//   Valid/ready handshake bundle for one elastic pipeline stage. It carries the
//   upstream side (InValid/InReady/D) and the downstream handshake
//   (OutValid/OutReady) of a pipe_skid_register.
//
//   modport slave  : the stage register itself
//   modport master : the surrounding logic (producer + consumer)
//
//   Signals
//     InValid   producer -> stage   upstream payload valid
//     InReady   stage -> producer   stage can accept a payload
//     D         producer -> stage   upstream payload, NrOfBits wide
//     OutValid  stage -> consumer   main entry valid
//     OutReady  consumer -> stage   downstream accepts
//
//   The tri-state payload output Q and its cs enable are plain ports of the
//   stage, because Q is resolved on a shared bus net together with other
//   drivers.
// -----------------------------------------------------------------------------
interface pipe_skid_register_if #(
  parameter int NrOfBits = 32
);

  logic                InValid;
  logic                InReady;
  logic [NrOfBits-1:0] D;
  logic                OutValid;
  logic                OutReady;

  modport slave (
    input  InValid,
    input  D,
    input  OutReady,
    output InReady,
    output OutValid
  );

  modport master (
    output InValid,
    output D,
    output OutReady,
    input  InReady,
    input  OutValid
  );

endinterface

// File: rtl/pipe_skid_register.sv
// -----------------------------------------------------------------------------
// pipe_skid_register
//   Elastic pipeline-stage register built as a 2-entry skid buffer with a
//   valid/ready handshake. It replaces the plain stage flip-flops between CPU
//   pipeline stages (e.g. MEM->WB) and between accelerator datapath stages,
//   adding back-pressure, a synchronous flush and a synchronous preset while
//   keeping the ClockEnable/Tick qualification and the cs tri-state output.
//
//   Parameters
//     NrOfBits     payload width
//     PresetValue  payload loaded into the main entry by Pre
//     StatsWidth   stall counter width (only used with PIPE_SKID_STATS_EN)
//
//   Ports
//     Clock        single clock, all state changes on the rising edge
//     Reset        asynchronous, active-low reset
//     ClockEnable  stage enable
//     Tick         clock-divider tick; the stage advances on ClockEnable & Tick
//     Flush        synchronous squash of all held entries (not gated by adv)
//     Pre          synchronous preset of the main entry (not gated by adv)
//     bus          handshake bundle (slave modport): InValid, InReady, D,
//                  OutValid, OutReady
//     cs           1 = Q driven high-Z; OutValid is not affected
//     Q            main entry payload, high-Z while cs = 1
//     StallCount   stall cycle counter (only with PIPE_SKID_STATS_EN)
//
//   Configuration macro
//     PIPE_SKID_STATS_EN  when defined, adds the StallCount port and a
//                         saturating counter of adv cycles with OutValid = 1
//                         and OutReady = 0, cleared by Reset and Flush.
// -----------------------------------------------------------------------------
module pipe_skid_register #(
  parameter int                  NrOfBits    = 32,
  parameter logic [NrOfBits-1:0] PresetValue = '0,
  parameter int                  StatsWidth  = 16
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  ClockEnable,
  input  logic                  Tick,
  input  logic                  Flush,
  input  logic                  Pre,
  pipe_skid_register_if.slave   bus,
  input  logic                  cs,
  output wire  [NrOfBits-1:0]   Q
`ifdef PIPE_SKID_STATS_EN
  ,
  output logic [StatsWidth-1:0] StallCount
`endif
);

  // Elaboration-time sanity check of the widths.
  if (NrOfBits < 1 || StatsWidth < 1) begin : g_bad_params
    $error("pipe_skid_register: NrOfBits and StatsWidth must be at least 1");
  end

  // EMPTY: nothing held, ONE: main entry valid, TWO: main and skid valid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [NrOfBits-1:0] main_q;
  logic [NrOfBits-1:0] main_d;
  logic [NrOfBits-1:0] skid_q;
  logic [NrOfBits-1:0] skid_d;
  logic                in_ready_q;
  logic                out_valid;
  logic                adv;
  logic                in_fire;
  logic                out_fire;

  // The stage only moves on qualified cycles. Both handshakes are gated by
  // adv so a valid&ready pair on a non-advancing cycle transfers nothing.
  assign adv       = ClockEnable & Tick;
  assign out_valid = (state_q != EMPTY);
  assign in_fire   = bus.InValid & in_ready_q & adv;
  assign out_fire  = out_valid & bus.OutReady & adv;

  assign bus.InReady  = in_ready_q;
  assign bus.OutValid = out_valid;

  // Q follows the main entry regardless of OutValid so a flushed or drained
  // stage still shows its last payload; cs releases the shared bus.
  assign Q = cs ? {NrOfBits{1'bz}} : main_q;

  // State and payload registers. InReady is kept as its own flop, loaded from
  // the next state, so the upstream sees a clean registered ready that is
  // low exactly while the skid entry is occupied.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != TWO);
    end
  end

  // Next-state and payload steering. Flush beats Pre, and both beat the
  // handshake; neither waits for adv. A payload arriving in the same cycle as
  // Flush or Pre is therefore dropped. Flush leaves the data registers alone
  // so Q keeps showing the old main payload. In the TWO state InReady is low,
  // so only the output side can fire, and the skid entry moves up into main.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (Flush) begin
      state_d = EMPTY;
    end else if (Pre) begin
      state_d = ONE;
      main_d  = PresetValue;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = ONE;
            main_d  = bus.D;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = bus.D;
          end else if (out_fire) begin
            state_d = EMPTY;
          end else if (in_fire) begin
            state_d = TWO;
            skid_d  = bus.D;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

`ifdef PIPE_SKID_STATS_EN
  logic [StatsWidth-1:0] stall_q;
  logic                  stall_cycle;

  assign stall_cycle = adv & out_valid & ~bus.OutReady;
  assign StallCount  = stall_q;

  // Stall statistics: one count per advancing cycle in which the stage holds
  // a valid payload that the consumer refuses. The counter sticks at
  // all-ones instead of wrapping, and Flush restarts the measurement.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      stall_q <= '0;
    end else if (Flush) begin
      stall_q <= '0;
    end else if (stall_cycle && (stall_q != {StatsWidth{1'b1}})) begin
      stall_q <= stall_q + StatsWidth'(1);
    end
  end
`endif

endmodule
